// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and float32 constants for the window sequencer
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_EMIT  = 3'd4
  } conv_state_e;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/window_counter.sv
// rtl/window_counter.sv - nested tap (kx, ky) and window origin (col, row) counters
module window_counter #(
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_tap,
  input  logic       step_window,
  output logic [7:0] kx,
  output logic [7:0] ky,
  output logic [7:0] col,
  output logic [7:0] row,
  output logic       last_tap,
  output logic       last_window
);

  localparam logic [7:0] K_LAST = 8'(KERNEL_SIZE - 1);
  localparam logic [7:0] C_LAST = 8'(IMG_WIDTH - KERNEL_SIZE);
  localparam logic [7:0] R_LAST = 8'(IMG_HEIGHT - KERNEL_SIZE);

  assign last_tap    = (kx == K_LAST) && (ky == K_LAST);
  assign last_window = (col == C_LAST) && (row == R_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      kx  <= '0;
      ky  <= '0;
      col <= '0;
      row <= '0;
    end else begin
      // Tap counters wrap back to 0 after the last tap, ready for the next window
      if (step_tap) begin
        if (kx == K_LAST) begin
          kx <= '0;
          ky <= (ky == K_LAST) ? 8'd0 : ky + 8'd1;
        end else begin
          kx <= kx + 8'd1;
        end
      end
      if (step_window) begin
        if (col == C_LAST) begin
          col <= '0;
          row <= (row == R_LAST) ? 8'd0 : row + 8'd1;
        end else begin
          col <= col + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - feeds K x K window operands to the float MAC PE and emits per-window sums
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8,
  parameter int IMG_ADDR_W  = 6,
  parameter int W_ADDR_W    = 4,
  parameter int PE_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [IMG_ADDR_W-1:0] img_addr,
  input  logic [31:0]           img_data,
  output logic [W_ADDR_W-1:0]   weight_addr,
  input  logic [31:0]           weight_data,
  output logic                  pe_reset,
  output logic [31:0]           floatA,
  output logic [31:0]           floatB,
  input  logic [31:0]           pe_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [7:0]            out_row,
  output logic [7:0]            out_col
);

  localparam logic [7:0] DRAIN_LAST = 8'(PE_LATENCY);

  conv_state_e state;
  logic        rd_valid;
  logic [7:0]  drain_cnt;
  logic [7:0]  kx;
  logic [7:0]  ky;
  logic [7:0]  col;
  logic [7:0]  row;
  logic        last_tap;
  logic        last_window;
  logic        handshake;
  logic [IMG_ADDR_W-1:0] pix_row;
  logic [IMG_ADDR_W-1:0] pix_col;

  assign handshake = (state == ST_EMIT) && out_ready;

  window_counter #(
    .KERNEL_SIZE(KERNEL_SIZE),
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_window_counter (
    .clk        (clk),
    .reset      (reset),
    .step_tap   (state == ST_FEED),
    .step_window(handshake),
    .kx         (kx),
    .ky         (ky),
    .col        (col),
    .row        (row),
    .last_tap   (last_tap),
    .last_window(last_window)
  );

  assign pix_row     = IMG_ADDR_W'(row) + IMG_ADDR_W'(ky);
  assign pix_col     = IMG_ADDR_W'(col) + IMG_ADDR_W'(kx);
  assign img_addr    = pix_row * IMG_ADDR_W'(IMG_WIDTH) + pix_col;
  assign weight_addr = W_ADDR_W'(ky) * W_ADDR_W'(KERNEL_SIZE) + W_ADDR_W'(kx);

  assign busy      = (state != ST_IDLE);
  assign pe_reset  = (state == ST_IDLE) || (state == ST_CLEAR);
  assign out_valid = (state == ST_EMIT);

  // Outside operand slots the PE keeps accumulating, so feed it +0
  assign floatA = rd_valid ? img_data    : FP32_ZERO;
  assign floatB = rd_valid ? weight_data : FP32_ZERO;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rd_valid  <= 1'b0;
      drain_cnt <= '0;
      done      <= 1'b0;
      out_data  <= FP32_ZERO;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      rd_valid <= (state == ST_FEED);
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          state <= ST_FEED;
        end
        ST_FEED: begin
          if (last_tap) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state    <= ST_EMIT;
            out_data <= pe_result;
            out_row  <= row;
            out_col  <= col;
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (last_window) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              state <= ST_CLEAR;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
